// File: rtl/seg7_pkg.sv
// Shared constants for seven-segment drivers: lit-high hex segment table (a..g = bits 6..0)
// and segment bit positions.
package seg7_pkg;

  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Entry n is the lit pattern for hex digit n (entry 0 in the lowest slice).
  localparam logic [15:0][6:0] SEG7_HEX = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to seven-segment decoder, lit-high polarity.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG7_HEX[nibble];
  end

endmodule

// File: rtl/seven_seg_mux_driver.sv
// Time-multiplexed N-digit seven-segment driver with per-slot anode blanking and
// frame-synchronous (tear-free) double-buffered display updates.
module seven_seg_mux_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 1024,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_num_digits
    $error("NUM_DIGITS must be in 1..16");
  end
  if (REFRESH_DIV < BLANK_CYCLES + 2) begin : g_bad_refresh_div
    $error("REFRESH_DIV must be at least BLANK_CYCLES+2");
  end

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    cnt_wrap, frame_end;

  logic [4*NUM_DIGITS-1:0] pend_data_q, act_data_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, act_dp_q;
  logic [NUM_DIGITS-1:0]   pend_en_q, act_en_q;

  logic [3:0]              cur_nibble;
  logic [6:0]              dec_seg;
  logic                    slot_lit;
  logic [NUM_DIGITS-1:0]   an_lit;
  logic [6:0]              seg_lit;
  logic                    dp_lit;

  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic                    frame_start_q;

  always_comb begin
    cnt_wrap  = (cnt_q == CNT_MAX);
    frame_end = cnt_wrap && (idx_q == IDX_MAX);
    cnt_d     = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // A load coinciding with the frame boundary bypasses pending so it is shown next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_en_q   <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_en_q    <= '0;
    end else begin
      if (load) begin
        pend_data_q <= data;
        pend_dp_q   <= dp_in;
        pend_en_q   <= digit_en;
      end
      if (frame_end) begin
        act_data_q <= load ? data     : pend_data_q;
        act_dp_q   <= load ? dp_in    : pend_dp_q;
        act_en_q   <= load ? digit_en : pend_en_q;
      end
    end
  end

  always_comb begin
    cur_nibble = act_data_q[4*idx_q +: 4];
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    slot_lit = (cnt_q >= CNT_BLANK) && act_en_q[idx_q];
    an_lit   = '0;
    if (slot_lit) begin
      an_lit[idx_q] = 1'b1;
    end
    seg_lit = slot_lit ? dec_seg : SEG_BLANK;
    dp_lit  = slot_lit && act_dp_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_q          <= {NUM_DIGITS{ACTIVE_LOW}};
      seg_q         <= {7{ACTIVE_LOW}};
      dp_q          <= ACTIVE_LOW;
      frame_start_q <= 1'b0;
    end else begin
      an_q          <= an_lit ^ {NUM_DIGITS{ACTIVE_LOW}};
      seg_q         <= seg_lit ^ {7{ACTIVE_LOW}};
      dp_q          <= dp_lit ^ ACTIVE_LOW;
      frame_start_q <= (cnt_q == '0) && (idx_q == '0);
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// Self-checking bench for seven_seg_mux_driver (4 digits, 8-cycle slots, 2 blank, active-low).
module tb_seven_seg_mux_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BL = 2;
  localparam int FR = ND * RD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seven_seg_mux_driver #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BL),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .data        (data),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  logic [6:0] hex_lit [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [3:0] an_on [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  // Reference model: position within the frame, plus pending/active display contents.
  int          m_pos = 0;
  logic [15:0] m_pend_data = '0, m_act_data = '0;
  logic [3:0]  m_pend_dp = '0, m_act_dp = '0, m_pend_en = '0, m_act_en = '0;
  int          m_slot, m_cnt;
  logic        m_lit;
  logic [3:0]  m_nib;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1, e_fs = 1'b0;

  always_comb begin
    m_slot = m_pos / RD;
    m_cnt  = m_pos % RD;
    m_lit  = (m_cnt >= BL) && m_act_en[m_slot];
    m_nib  = m_act_data[m_slot*4 +: 4];
  end

  always @(posedge clk) begin
    if (reset) begin
      m_pos <= 0;
      m_pend_data <= '0; m_pend_dp <= '0; m_pend_en <= '0;
      m_act_data  <= '0; m_act_dp  <= '0; m_act_en  <= '0;
      e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1; e_fs <= 1'b0;
    end else begin
      e_an  <= m_lit ? ~(4'b0001 << m_slot) : 4'hF;
      e_seg <= m_lit ? ~hex_lit[m_nib] : 7'h7F;
      e_dp  <= m_lit ? ~m_act_dp[m_slot] : 1'b1;
      e_fs  <= (m_pos == 0);
      if (m_pos == FR - 1) begin
        m_act_data <= load ? data : m_pend_data;
        m_act_dp   <= load ? dp_in : m_pend_dp;
        m_act_en   <= load ? digit_en : m_pend_en;
      end
      if (load) begin
        m_pend_data <= data; m_pend_dp <= dp_in; m_pend_en <= digit_en;
      end
      m_pos <= (m_pos + 1) % FR;
    end
  end

  task automatic do_load(input logic [15:0] d, input logic [3:0] en, input logic [3:0] p);
    data = d; digit_en = en; dp_in = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && n < 3 * FR) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("FAIL %s_frame_wait: frame_start=%b after %0d cycles, required 1", name,
               frame_start, n);
    end
  endtask

  task automatic test_reset();
    int last = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL reset_hold: got an=%h seg=%h dp=%b fs=%b, required F 7f 1 0",
                 an, seg, dp, frame_start);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_frame: frame_start=%b, required 1", frame_start);
    end
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
        failures++;
        $display("FAIL reset_model k=%0d: got %h, required %h", k, {an, seg, dp, frame_start},
                 {e_an, e_seg, e_dp, e_fs});
      end
      checks++;
      if (an !== 4'hF) begin
        failures++;
        $display("FAIL reset_blank k=%0d: an=%h, required F", k, an);
      end
      if (frame_start === 1'b1) begin
        checks++;
        if (k - last != FR) begin
          failures++;
          $display("FAIL reset_period: frame_start period %0d, required %0d", k - last, FR);
        end
        last = k;
      end
    end
  endtask

  // Checks one full frame starting at a frame_start negedge against the model and against
  // explicit per-slot values; ends on the next frame_start negedge.
  task automatic check_frame(input string name, input logic [6:0] lit_seg [4],
                             input logic [3:0] en, input logic [3:0] p);
    int s, c;
    logic lit;
    logic [3:0] x_an;
    logic [6:0] x_seg;
    logic x_dp;
    for (int k = 0; k < FR; k++) begin
      s = k / RD; c = k % RD;
      lit   = (c >= BL) && en[s];
      x_an  = lit ? an_on[s] : 4'hF;
      x_seg = lit ? ~lit_seg[s] : 7'h7F;
      x_dp  = lit ? ~p[s] : 1'b1;
      checks++;
      if ({an, seg, dp, frame_start} !== {x_an, x_seg, x_dp, k == 0}) begin
        failures++;
        $display("FAIL %s k=%0d: got an=%h seg=%h dp=%b fs=%b, required an=%h seg=%h dp=%b fs=%b",
                 name, k, an, seg, dp, frame_start, x_an, x_seg, x_dp, k == 0);
      end
      checks++;
      if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
        failures++;
        $display("FAIL %s_model k=%0d: got %h, required %h", name, k,
                 {an, seg, dp, frame_start}, {e_an, e_seg, e_dp, e_fs});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_pattern();
    logic [6:0] t [4] = '{7'h7E, 7'h30, 7'h6D, 7'h79};
    do_load(16'h3210, 4'hF, 4'b0100);
    wait_frame("pattern");
    check_frame("pattern", t, 4'hF, 4'b0100);
  endtask

  task automatic test_midframe();
    logic [6:0] t [4] = '{7'h4E, 7'h3D, 7'h4F, 7'h47};
    int n = 0;
    repeat (10) @(negedge clk);
    do_load(16'hFEDC, 4'hF, 4'b0000);
    while (frame_start !== 1'b1 && n < 3 * FR) begin
      checks++;
      if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
        failures++;
        $display("FAIL midframe_old n=%0d: got %h, required %h", n,
                 {an, seg, dp, frame_start}, {e_an, e_seg, e_dp, e_fs});
      end
      @(negedge clk);
      n++;
    end
    check_frame("midframe", t, 4'hF, 4'b0000);
  endtask

  task automatic test_enables();
    logic [6:0] t [4] = '{7'h7E, 7'h30, 7'h6D, 7'h79};
    do_load(16'h3210, 4'b1010, 4'b0000);
    wait_frame("enables");
    check_frame("enables", t, 4'b1010, 4'b0000);
  endtask

  task automatic test_bypass();
    logic [6:0] t1 [4] = '{7'h5F, 7'h7B, 7'h77, 7'h5B};
    logic [6:0] t2 [4] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
    int n = 0;
    while (m_pos != FR - 1 && n < 3 * FR) begin
      @(negedge clk);
      n++;
    end
    do_load(16'h5A96, 4'hF, 4'b1001);
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("FAIL bypass_frame: frame_start=%b, required 1", frame_start);
    end
    check_frame("bypass", t1, 4'hF, 4'b1001);
    do_load(16'h1111, 4'hF, 4'b1111);
    repeat (5) @(negedge clk);
    do_load(16'h8888, 4'hF, 4'b0000);
    wait_frame("two_loads");
    check_frame("two_loads", t2, 4'hF, 4'b0000);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6 * FR; k++) begin
      if ($urandom_range(15) == 0) begin
        data = 16'($urandom); digit_en = 4'($urandom); dp_in = 4'($urandom); load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
        failures++;
        $display("FAIL random k=%0d: got %h, required %h", k, {an, seg, dp, frame_start},
                 {e_an, e_seg, e_dp, e_fs});
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_load(16'h3210, 4'hF, 4'hF);
    wait_frame("reset_mid");
    while (m_pos != 2 * RD + 4 && n < 3 * FR) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (an !== 4'hB) begin
      failures++;
      $display("FAIL reset_mid_lit: an=%h, required b", an);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_off: got an=%h seg=%h dp=%b fs=%b, required F 7f 1 0",
               an, seg, dp, frame_start);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_restart: frame_start=%b, required 1", frame_start);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1} ||
          {an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
        failures++;
        $display("FAIL reset_mid_blank k=%0d: got %h, required %h", k,
                 {an, seg, dp, frame_start}, {e_an, e_seg, e_dp, e_fs});
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_midframe();
    test_enables();
    test_bypass();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seven_seg_mux_driver.md
# seven_seg_mux_driver

Parametrised time-multiplexed seven-segment display driver for N digits. It shows hexadecimal nibbles with per-digit decimal point and digit enable, and inserts anode blanking between slots to suppress ghosting. Display updates are tear-free: new values are double-buffered and committed only at frame boundaries. It sits between UART/status logic and the board's common-anode display, and replaces the fixed four-digit driver.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1..16)
- REFRESH_DIV, 1024, clock cycles per digit slot (≥ BLANK_CYCLES+2)
- BLANK_CYCLES, 16, cycles at start of each slot with all anodes off
- ACTIVE_LOW, 1, 1: `an`, `seg` and `dp` are driven low to light; 0: driven high to light

- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- load  in  1  one-cycle strobe that captures `data`, `dp_in` and `digit_en` into the pending buffer
- data  in  4*NUM_DIGITS  hex nibbles; digit i = data[4i+3:4i], digit 0 rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit
- digit_en  in  NUM_DIGITS  1 = digit lit in its slot
- an  out  NUM_DIGITS  anode drives, registered
- seg  out  7  segments; seg[6]=a … seg[0]=g, registered
- dp  out  1  decimal point, registered
- frame_start  out  1  one-cycle pulse when digit 0's slot begins at the outputs

## Operation
- Prescaler `cnt` counts 0..REFRESH_DIV-1 and wraps. Digit index `idx` increments on each wrap and goes from NUM_DIGITS-1 back to 0. With NUM_DIGITS=1, `idx` is constant 0.
- Buffers:
  - `pending` captures inputs on `load`.
  - `active` copies `pending` at a frame boundary, defined as the `cnt` wrap while `idx`=NUM_DIGITS-1.
  - If `load` and the boundary coincide, `active` takes the `load` inputs directly (bypass), and `pending` captures them too.
  - Multiple loads within a frame: only the last one is displayed.
- Per-cycle output logic, "lit" polarity, inverted when ACTIVE_LOW=1:
  - cnt < BLANK_CYCLES, or active.digit_en[idx]=0: all anodes off, seg off, dp off.
  - Otherwise: an[idx] on, all other anodes off, seg = hex decode of active nibble idx, dp = active.dp_in[idx].
- Hex decode (lit=1, order a..g): 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 b:1F C:4E d:3D E:4F F:47.
- No state machine beyond the cnt/idx counters. At most one anode is on in any cycle, including across slot boundaries.

## Timing
- Outputs are registered and lag the (cnt, idx) state by exactly 1 cycle.
- Slot i has its anode on for REFRESH_DIV−BLANK_CYCLES cycles.
- A full frame is NUM_DIGITS·REFRESH_DIV cycles.
- `frame_start` pulses in the same cycle the outputs first reflect (cnt=0, idx=0), which is once per frame.
- Latency from `load` to display: the new data appears in the first digit-0 slot after the next frame boundary. Worst case ≈ one frame plus 1 cycle.
- Reset (synchronous, overrides `load`): the cycle after reset is asserted, cnt=0, idx=0, pending and active are all zero (digit_en=0), every output is off (an all 1s, seg=7F, dp=1 when ACTIVE_LOW), and frame_start=0. The display stays blank until a load is committed.
- Reset mid-slot: outputs are off on the next cycle. After reset deasserts, counting restarts with slot 0. The first frame_start occurs 1 cycle after the first clock edge with reset low.

## Structure
- Package `seg7_pkg`: the 16-entry hex→segment constant table (lit=1 polarity) and segment-index constants (SEG_A=6 … SEG_G=0).
- Sub-module `hex_to_seg7`: combinational 4→7 decoder built from the package table. The polarity inversion is applied in the top-level output register, not in the decoder.
- Top level holds the prescaler, index counter, pending/active buffers, and output registers. Counter widths are $clog2 of the parameter, with a minimum of 1.
- Elaboration-time checks enforce the parameter ranges listed under Interface.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1.
- Reset held 3 cycles, then released → an=4'hF, seg=7'h7F, dp=1 throughout reset; no anode is ever lit before the first load commits; frame_start period = 32 cycles.
- load with data=16'h3210, digit_en=4'hF, dp_in=4'b0100 → after the next boundary, each slot shows 2 blank cycles followed by 6 lit cycles:
  - slot 0: an=4'hE, seg=~7E
  - slot 1: an=4'hD, seg=~30
  - slot 2: an=4'hB, seg=~6D, dp=0
  - slot 3: an=4'h7, seg=~79
- load data=16'hFEDC mid-frame → the current frame keeps showing 3210; the next frame shows C,d,E,F (~4E, ~3D, ~4F, ~47).
- digit_en=4'b1010 → slots 0 and 2 keep all anodes off for all 8 cycles; slots 1 and 3 light normally.
- load asserted exactly at the boundary cycle → the new value is displayed in the very next frame (bypass). Two loads in one frame → only the second is displayed.
- reset asserted during slot 2 lit cycles → outputs are all off on the next cycle; after release, slot 0 restarts and active is cleared (blank display).
